// File: rtl/alu_result_serializer.sv
`default_nettype none
// ============================================================================
// alu_result_serializer: buffers ALU results in a FIFO and sends each one as
// a 12-bit serial frame (start, result LSB first, carry, overflow, stop).
// Revision: 1.0
// ============================================================================
module alu_result_serializer #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_result,
  input  logic                   in_carry,
  input  logic                   in_overflow,
  output logic                   ser_out,
  output logic                   ser_frame,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] C_DEPTH    = LVL_W'(DEPTH);
  localparam logic [7:0]       C_BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       C_IDX_LAST = 4'd11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [11:0]        shift_q, shift_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               push;
  logic               pop;

  assign in_ready  = !rst && (level_q < C_DEPTH);
  assign push      = in_valid && in_ready;
  assign ser_out   = shift_q[0];
  assign ser_frame = (state_q == S_SHIFT);
  assign busy      = (state_q == S_SHIFT);
  assign level     = level_q;

  // The shifter holds the whole frame; bit 0 is the line, ones fill from the top.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_SHIFT;
          shift_d = {1'b1, mem_q[rd_ptr_q], 1'b0};
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d = 8'd0;
          if (idx_q == C_IDX_LAST) begin
            idx_d = 4'd0;
            if (level_q != '0) begin
              pop     = 1'b1;
              shift_d = {1'b1, mem_q[rd_ptr_q], 1'b0};
            end else begin
              state_d = S_IDLE;
              shift_d = '1;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            shift_d = {1'b1, shift_q[11:1]};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        shift_d = '1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '1;
      idx_q    <= 4'd0;
      cnt_q    <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_overflow, in_carry, in_result};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_serializer.sv
`default_nettype none
// tb_alu_result_serializer: scoreboard bench driving two serializers
// (1 and 3 clocks per bit) with directed and random traffic.
module tb_alu_result_serializer;

  localparam int DEPTH = 4;
  localparam int NI    = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid    [NI];
  logic                   in_ready    [NI];
  logic [7:0]             in_result   [NI];
  logic                   in_carry    [NI];
  logic                   in_overflow [NI];
  logic                   ser_out     [NI];
  logic                   ser_frame   [NI];
  logic                   busy        [NI];
  logic [$clog2(DEPTH):0] level       [NI];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per instance: DUT, queue of accepted words, and a frame-level reference model.
  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int CPB  = (k == 0) ? 1 : 3;
    localparam int FLEN = 12 * CPB;

    logic [9:0] exp_q [$];
    logic [9:0] cur      = '0;
    logic [9:0] hs_word  = '0;
    logic       hs_pend  = 1'b0;
    logic       rst_pend = 1'b1;
    int         fcyc     = -1;
    int         lvl      = 0;
    int         pend     = 0;

    alu_result_serializer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[k]),
      .in_ready   (in_ready[k]),
      .in_result  (in_result[k]),
      .in_carry   (in_carry[k]),
      .in_overflow(in_overflow[k]),
      .ser_out    (ser_out[k]),
      .ser_frame  (ser_frame[k]),
      .busy       (busy[k]),
      .level      (level[k])
    );

    always @(negedge clk) begin
      logic [11:0] frm;
      if (rst_pend) begin
        exp_q.delete();
        lvl  = 0;
        fcyc = -1;
      end else begin
        if (fcyc < 0 || fcyc == FLEN - 1) begin
          if (lvl > 0) begin
            cur  = exp_q.pop_front();
            lvl  = lvl - 1;
            fcyc = 0;
          end else begin
            fcyc = -1;
          end
        end else begin
          fcyc = fcyc + 1;
        end
        if (hs_pend) begin
          exp_q.push_back(hs_word);
          lvl = lvl + 1;
        end
      end
      frm = {1'b1, cur, 1'b0};
      check($sformatf("i%0d ser_out", k), int'(ser_out[k]),
            (fcyc < 0) ? 1 : int'(frm[fcyc / CPB]));
      check($sformatf("i%0d ser_frame", k), int'(ser_frame[k]), (fcyc >= 0) ? 1 : 0);
      check($sformatf("i%0d busy", k), int'(busy[k]), (fcyc >= 0) ? 1 : 0);
      check($sformatf("i%0d level", k), int'(level[k]), lvl);
      check($sformatf("i%0d in_ready", k), int'(in_ready[k]),
            (!rst && lvl < DEPTH) ? 1 : 0);
      hs_pend  = in_valid[k] && !rst && (lvl < DEPTH);
      hs_word  = {in_overflow[k], in_carry[k], in_result[k]};
      rst_pend = rst;
      pend     = exp_q.size() + ((fcyc >= 0) ? 1 : 0);
    end
  end

  function automatic int pend_of(input int k);
    return (k == 0) ? g_inst[0].pend : g_inst[1].pend;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns the edge number at which the word was taken.
  task automatic send(input int k, input logic [9:0] w, output int edge_n);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    {in_overflow[k], in_carry[k], in_result[k]} = w;
    @(negedge clk);
    while (!in_ready[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    edge_n = cyc;
    in_valid[k] = 1'b0;
  endtask

  task automatic glance(input int k);
    in_valid[k] = 1'b1;
    {in_overflow[k], in_carry[k], in_result[k]} = 10'($urandom);
    step(1);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while (pend_of(k) != 0 && n < 3000) begin
      step(1);
      n++;
    end
    check("drain", pend_of(k), 0);
  endtask

  initial begin
    int e, e0, ea, cnt;
    logic [11:0] cap;
    logic [39:0] s;
    foreach (in_valid[i]) begin
      in_valid[i]    = 1'b0;
      in_result[i]   = 8'h00;
      in_carry[i]    = 1'b0;
      in_overflow[i] = 1'b0;
    end
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", int'(in_ready[0]), 1);
    step(1);

    // Single frame: 0xA5, carry 1, overflow 0
    send(0, {1'b0, 1'b1, 8'hA5}, e);
    @(negedge clk);
    check("sf_level", int'(level[0]), 1);
    check("sf_idle_first", int'(ser_frame[0]), 0);
    cap = '0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cap[i] = ser_out[0];
      cnt += int'(busy[0]);
    end
    @(negedge clk);
    check("sf_line_high", int'(ser_out[0]), 1);
    check("sf_frame_low", int'(ser_frame[0]), 0);
    for (int i = 0; i < 3; i++) begin
      cnt += int'(busy[0]);
      @(negedge clk);
    end
    check("sf_bits", int'(cap), 'hB4A);
    check("sf_busy_cycles", cnt, 12);
    step(1);

    // Fill and backpressure with six distinct words
    wait_drain(0);
    step(2);
    send(0, 10'h101, e0);
    for (int i = 1; i < 5; i++) send(0, 10'(10'h101 + 37 * i), e);
    @(negedge clk);
    check("bp_level_full", int'(level[0]), 4);
    check("bp_ready_low", int'(in_ready[0]), 0);
    send(0, 10'h3C7, e);
    check("bp_word5_edge", e - e0, 14);

    // Push in the reload cycle with level 2
    wait_drain(0);
    step(2);
    send(0, 10'h0F0, ea);
    send(0, 10'h2A5, e);
    send(0, 10'h15A, e);
    while (cyc < ea + 12) step(1);
    send(0, 10'h3FF, e);
    check("pp_edge", e - ea, 13);
    @(negedge clk);
    check("pp_level", int'(level[0]), 2);
    check("pp_no_gap", int'(ser_frame[0]), 1);
    check("pp_start_bit", int'(ser_out[0]), 0);
    step(1);

    // Reset during bit 5 with level 3
    wait_drain(0);
    step(2);
    send(0, 10'h1E3, e0);
    for (int i = 1; i < 4; i++) send(0, 10'(10'h055 * i), e);
    while (cyc < e0 + 6) step(1);
    rst = 1'b1;
    @(negedge clk);
    check("rs_level_before", int'(level[0]), 3);
    check("rs_ready_in_reset", int'(in_ready[0]), 0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rs_ser_out", int'(ser_out[0]), 1);
    check("rs_ser_frame", int'(ser_frame[0]), 0);
    check("rs_busy", int'(busy[0]), 0);
    check("rs_level", int'(level[0]), 0);
    check("rs_ready_after", int'(in_ready[0]), 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(ser_frame[0]);
    end
    check("rs_no_frames", cnt, 0);
    step(1);

    // Push into a drained, idle FIFO
    step(10);
    send(0, 10'h2C3, e);
    @(negedge clk);
    check("dr_level", int'(level[0]), 1);
    check("dr_idle", int'(ser_frame[0]), 0);
    @(negedge clk);
    check("dr_start_frame", int'(ser_frame[0]), 1);
    check("dr_start_bit", int'(ser_out[0]), 0);
    step(1);
    wait_drain(0);

    // Random traffic, one clock per bit
    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) glance(0);
      if (r >= 4) step(int'($urandom_range(1, 20)));
      send(0, 10'($urandom), e);
    end
    wait_drain(0);

    // Bit stretching: 0x01, carry 0, overflow 1, three clocks per bit
    send(1, {1'b1, 1'b0, 8'h01}, e);
    @(negedge clk);
    s = '0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s[i] = ser_out[1];
      cnt += int'(ser_frame[1]);
    end
    check("bs_frame_len", cnt, 36);
    check("bs_start", int'(s[2:0]), 0);
    check("bs_result0", int'(s[5:3]), 7);
    check("bs_carry", int'(s[29:27]), 0);
    check("bs_overflow", int'(s[32:30]), 7);
    check("bs_stop", int'(s[35:33]), 7);
    step(1);
    wait_drain(1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 50)));
      send(1, 10'($urandom), e);
    end
    wait_drain(1);
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
